// File: rtl/logic_gate_unit.sv
// Registered eight-function bitwise gate unit with a valid/ready delay pipeline.
// Optional result-toggle statistics are built when GATE_STATS_EN is defined.
module logic_gate_unit #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef GATE_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      toggle_count,
`endif
    output logic [WIDTH-1:0] Y
);

    localparam int unsigned CNT_W = 16;

    logic [WIDTH-1:0]  func_c;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] load_c;

    // Gate function selected by mode
    always_comb begin
        func_c = ~(A | B);
        case (mode)
            3'b000:  func_c = ~(A | B);
            3'b001:  func_c = A | B;
            3'b010:  func_c = ~(A & B);
            3'b011:  func_c = A & B;
            3'b100:  func_c = A ^ B;
            3'b101:  func_c = ~(A ^ B);
            3'b110:  func_c = ~A;
            3'b111:  func_c = A;
            default: func_c = ~(A | B);
        endcase
    end

    // A stage may load unless it and every stage after it is full and the sink stalls
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        load_c    = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail & valid_q[k];
            load_c[k] = out_ready | ~full_tail;
        end
    end

    assign in_ready  = load_c[0];
    assign out_valid = valid_q[STAGES-1];
    assign Y         = data_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (load_c[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= func_c;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load_c[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

`ifdef GATE_STATS_EN
    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] cnt_q;

    // Count delivered results that differ from the previously delivered one
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else if (out_valid && out_ready) begin
            prev_q <= Y;
            if ((Y != prev_q) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign toggle_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit (WIDTH=8, STAGES=2); stats checks build with GATE_STATS_EN.
module tb_logic_gate_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Y;
`ifdef GATE_STATS_EN
    logic        stats_clr;
    logic [15:0] toggle_count;
`endif

    logic_gate_unit #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef GATE_STATS_EN
        .stats_clr    (stats_clr),
        .toggle_count (toggle_count),
`endif
        .Y         (Y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        int         cyc;
        bit         lat;
    } sb_t;

    sb_t        exp_q [$];
    string      tag_q [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    int         n_out    = 0;
    logic [7:0] cur_exp;
    string      cur_tag;
    bit         cur_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gate_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] m);
        case (m)
            3'd0:    return ~(a | b);
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    sb_t   e;
                    string t;
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check(t, 64'(Y), 64'(e.exp));
                    if (e.lat) check({t, "_lat"}, 64'(cyc - e.cyc), 64'd2);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{exp: cur_exp, cyc: cyc, lat: cur_lat});
                tag_q.push_back(cur_tag);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                        input logic [7:0] e, input string tag);
        bit ok;
        cur_exp  = e;
        cur_tag  = tag;
        A        = a;
        B        = b;
        mode     = m;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check({tag, "_accept_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        sweep_exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        mode      = '0;
        cur_exp   = '0;
        cur_tag   = "none";
        cur_lat   = 1'b0;
`ifdef GATE_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(Y), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef GATE_STATS_EN
        check("rst_toggle", 64'(toggle_count), 64'd0);
`endif
        @(posedge clk);
        #1;

        // NOR truth table on bit 0
        cur_lat = 1'b1;
        send(8'h00, 8'h00, 3'b000, 8'hFF, "nor_00");
        send(8'h00, 8'h01, 3'b000, 8'hFE, "nor_01");
        send(8'h01, 8'h00, 3'b000, 8'hFE, "nor_10");
        send(8'h01, 8'h01, 3'b000, 8'hFE, "nor_11");
        drain("nor");

        // Mode sweep, back-to-back
        for (int i = 0; i < 8; i++) begin
            send(8'hC5, 8'h3A, 3'(i), sweep_exp[i], $sformatf("sweep_m%0d", i));
        end
        drain("sweep");

        // Backpressure
        cur_lat   = 1'b0;
        out_ready = 1'b0;
        base      = n_out;
        send(8'h11, 8'h22, 3'b001, 8'h33, "bp_op1");
        send(8'h44, 8'h88, 3'b100, 8'hCC, "bp_op2");
        cur_exp  = 8'h5A;
        cur_tag  = "bp_op3";
        A        = 8'h5A;
        B        = 8'hFF;
        mode     = 3'b011;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_full", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_hold", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_with_drain", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain("bp");
        check("bp_count", 64'(n_out - base), 64'd3);

        // Mode change mid-stream
        cur_lat = 1'b1;
        send(8'hF0, 8'h0F, 3'b000, 8'h00, "mchg_nor");
        send(8'hF0, 8'h0F, 3'b100, 8'hFF, "mchg_xor");
        drain("mchg");

        // Random operands and modes
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [2:0] rm;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 3'($urandom_range(0, 7));
            send(ra, rb, rm, gate_model(ra, rb, rm), $sformatf("rand%0d", i));
        end
        drain("rand");

        // Reset with two results in flight
        cur_lat   = 1'b0;
        out_ready = 1'b0;
        send(8'hAA, 8'h55, 3'b001, 8'hFF, "mrst_op1");
        send(8'hAA, 8'h55, 3'b100, 8'hFF, "mrst_op2");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        tag_q.delete();
        @(negedge clk);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_y", 64'(Y), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        base = n_out;
        repeat (6) @(posedge clk);
        #1;
        check("mrst_no_stale", 64'(n_out - base), 64'd0);

`ifdef GATE_STATS_EN
        send(8'h00, 8'h00, 3'b111, 8'h00, "st_0");
        send(8'h00, 8'h00, 3'b111, 8'h00, "st_1");
        send(8'hFF, 8'h00, 3'b111, 8'hFF, "st_2");
        send(8'hFF, 8'h00, 3'b111, 8'hFF, "st_3");
        send(8'h0F, 8'h00, 3'b111, 8'h0F, "st_4");
        drain("st");
        @(negedge clk);
        check("st_toggle_count", 64'(toggle_count), 64'd2);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(8'hF0, 8'h00, 3'b111, 8'hF0, "st_clr_op");
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = out_valid;
            end
            check("st_wait_valid", 64'(seen), 64'd1);
        end
        @(posedge clk);
        #1;
        stats_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        check("st_clear_wins", 64'(toggle_count), 64'd0);
        drain("st_clr");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, registered, multi-function bitwise gate unit. It applies one of eight two-operand logic functions to WIDTH-bit operands: NOR, OR, NAND, AND, XOR, XNOR, NOT-A and pass-A. Operands move through a STAGES-deep valid/ready pipeline. It replaces the team's single-bit combinational gates wherever vector operands, selectable function or flow control are needed. It sits between any valid/ready producer and consumer in the datapath.

## Interface
- WIDTH, 8, operand and result width in bits (1..64)
- STAGES, 2, pipeline depth in register stages (1..4)
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk
- in_valid  input  1  A, B and mode are valid
- in_ready  output  1  unit accepts the operand this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- mode  input  3  function select (see Operation)
- out_valid  output  1  Y is valid
- out_ready  input  1  consumer accepts Y this cycle
- Y  output  WIDTH  result
- stats_clr  input  1  clears toggle_count (present only with GATE_STATS_EN)
- toggle_count  output  16  count of delivered results that differ from the previous delivered result (present only with GATE_STATS_EN)

## Operation
- mode encoding, bitwise across WIDTH:
  - 000: ~(A|B), NOR (the default function)
  - 001: A|B
  - 010: ~(A&B)
  - 011: A&B
  - 100: A^B
  - 101: ~(A^B)
  - 110: ~A
  - 111: A
- The function is computed combinationally at the input and captured into stage 0. Stages 1..STAGES-1 are pure delay registers, each carrying a data word and a valid bit.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stage k loads when stage k is empty, or when stage k's content moves on in the same cycle.
- The last stage moves on when out_ready is high.
- in_ready = ~valid[0] | advance[0]. This is a combinational ready chain from out_ready; there are no bubbles at full throughput.
- Y = data[STAGES-1]. out_valid = valid[STAGES-1].
- Ordering is strictly FIFO. Each transfer is computed with the mode sampled in its own input cycle; changing mode mid-stream never affects results already captured.
- Protocol rule: once out_valid is high, Y holds stable until out_ready is high. Producers must follow the same rule on in_valid.

## Timing
- Reset, when rst is high at a rising edge:
  - all valid bits = 0, data registers = 0
  - out_valid = 0, Y = 0
  - in_ready = 1 in the cycle after reset
  - toggle_count = 0
- Reset mid-operation discards all in-flight results. No partial result is delivered.
- Latency: an accepted operand appears on Y exactly STAGES cycles after acceptance, provided out_ready is held high.
- Throughput is one result per cycle while out_ready is high.
- Backpressure: with out_ready low, the pipeline fills to STAGES entries. in_ready then drops in the same cycle the last free stage fills.
- Simultaneous in and out transfers with the pipe full are legal. in_ready stays 1 and occupancy is unchanged.
- Operand accepted with in_valid high and mode = X: not defined; the bench must not drive it.

## Configuration
- GATE_STATS_EN
  - Defined:
    - stats_clr and toggle_count exist.
    - On each output transfer whose Y differs from the Y of the previous output transfer, toggle_count increments by 1.
    - The first transfer after reset or clear compares against 0.
    - toggle_count saturates at 16'hFFFF.
    - stats_clr zeroes the counter and the stored previous Y. If stats_clr and a counted transfer occur together, clear wins and the counter = 0.
  - Undefined: both ports and all counter logic are absent. Datapath behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=8, STAGES=2.
- Reset, then exhaustive single-bit NOR truth table on bit 0 (mode=000): A/B = 00, 01, 10, 11 -> Y[0] = 1, 0, 0, 0, each Y exactly 2 cycles after acceptance.
- Mode sweep with A=8'hC5, B=8'h3A and out_ready=1 -> Y, for modes 000 through 111 in order = 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5, delivered back-to-back, in order.
- Backpressure: hold out_ready=0 and offer 3 operands -> 2 accepted, in_ready=0 on the third offer. Then raise out_ready -> results drain in order with no loss or duplication, and the third operand is accepted in the same cycle the first result leaves.
- Mode change mid-stream: send A=8'hF0, B=8'h0F with mode 000, then the same operands with mode 100 in the next cycle -> Y = 8'h00 then 8'hFF.
- Reset mid-operation: assert rst with 2 results in flight -> out_valid=0 and Y=0 on the next cycle, and no stale result is ever delivered.
- GATE_STATS_EN: deliver Y = 00, 00, FF, FF, 0F -> toggle_count = 2. Then pulse stats_clr coincident with a differing transfer -> toggle_count = 0.
